// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable, row/col counters,
// sync/blank decodes and an end-of-frame strobe.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       CLOCK_50M,
    input  logic       reset_L,
    output logic       pix_en,
    output logic       HS,
    output logic       VS,
    output logic       blank,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    COL_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]    ROW_LAST = 10'(V_TOTAL - 1);

    // 11-bit bounds so a sync pulse ending exactly at 1024 still decodes
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end

    logic [DW-1:0] div;
    logic          col_last;
    logic          row_last;
    logic [10:0]   col_x;
    logic [10:0]   row_x;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign col_x    = {1'b0, col};
    assign row_x    = {1'b0, row};

    // Clock divider: wraps after CLK_DIV-1, pix_en marks the last phase
    always_ff @(posedge CLOCK_50M or negedge reset_L) begin
        if (!reset_L) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    // Raster counters: col every pixel, row at end of each line
    always_ff @(posedge CLOCK_50M or negedge reset_L) begin
        if (!reset_L) begin
            col <= '0;
            row <= '0;
        end else if (pix_en) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? 10'd0 : row + 10'd1;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    // Zero-latency decodes from the counter registers
    always_comb begin
        pix_en    = (div == DIV_LAST);
        HS        = 1'b1;
        VS        = 1'b1;
        blank     = 1'b0;
        frame_end = 1'b0;
        if (col_x >= HS_START && col_x < HS_END) begin
            HS = 1'b0;
        end
        if (row_x >= VS_START && row_x < VS_END) begin
            VS = 1'b0;
        end
        if (col_x >= H_VIS || row_x >= V_VIS) begin
            blank = 1'b1;
        end
        frame_end = pix_en & col_last & row_last;
    end

endmodule
